alu_decode_stage: RTL and testbench

ALU_DECODE_STAGE -- requirements
Module: alu_decode_stage

---
 rtl/alu_decode_pkg.sv | 51 +++++
 rtl/alu_decode_comb.sv | 114 +++++++++++
 rtl/alu_decode_stage.sv | 90 +++++++++
 tb/tb_alu_decode_stage.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_decode_pkg.sv
// alu_decode_pkg
//   Definitions shared by the ALU decode stage and the execution unit:
//   RV64I opcode constants, funct7 patterns, the FuncClass / ShiftFn /
//   LogicFn encodings, and the decoded bundle struct.
package alu_decode_pkg;

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        FC_LOGIC = 2'b00,
        FC_SHIFT = 2'b01,
        FC_SLT   = 2'b10,
        FC_SLTU  = 2'b11
    } func_class_e;

    typedef enum logic [1:0] {
        SF_PASS = 2'b00,
        SF_SLL  = 2'b01,
        SF_SRL  = 2'b10,
        SF_SRA  = 2'b11
    } shift_fn_e;

    typedef enum logic [1:0] {
        LF_AND    = 2'b00,
        LF_OR     = 2'b01,
        LF_XOR    = 2'b10,
        LF_PASS_B = 2'b11
    } logic_fn_e;

    typedef struct packed {
        func_class_e func_class;
        shift_fn_e   shift_fn;
        logic_fn_e   logic_fn;
        logic        addn_sub;
        logic        ext_word;
        logic        b_sel;
        logic [63:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        illegal;
    } decode_t;

endpackage

// File: rtl/alu_decode_comb.sv
// alu_decode_comb
//   Purely combinational RV64I integer-ALU decoder.
//   Ports:
//     inst  in  32  instruction word
//     dec   out     decoded bundle (controls, immediate, reg addresses, illegal)
//   Optional feature: define ALU_DECODE_WORD_OPS_EN to decode OP-32 and
//   OP-IMM-32; otherwise those opcodes decode as illegal and ext_word is 0.
module alu_decode_comb
    import alu_decode_pkg::*;
(
    input  logic [31:0] inst,
    output decode_t     dec
);

    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic               alt;
    logic               legal;
    logic signed [63:0] imm_i;
    logic signed [63:0] imm_u;
    decode_t            ctl;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];
    assign alt    = (funct7 == F7_ALT);
    assign imm_i  = {{52{inst[31]}}, inst[31:20]};
    assign imm_u  = {{32{inst[31]}}, inst[31:12], 12'b0};

    // Shared funct3 -> execution-unit control mapping for register and
    // immediate forms; alt selects SUB or SRA where it applies.
    function automatic decode_t alu_fields(input logic [2:0] f3, input logic alt_sel);
        decode_t r;
        r = '0;
        case (f3)
            3'b000: begin r.func_class = FC_SHIFT; r.shift_fn = SF_PASS; r.addn_sub = alt_sel; end
            3'b001: begin r.func_class = FC_SHIFT; r.shift_fn = SF_SLL; end
            3'b010: begin r.func_class = FC_SLT;   r.addn_sub = 1'b1; end
            3'b011: begin r.func_class = FC_SLTU;  r.addn_sub = 1'b1; end
            3'b100: begin r.func_class = FC_LOGIC; r.logic_fn = LF_XOR; end
            3'b101: begin r.func_class = FC_SHIFT; r.shift_fn = alt_sel ? SF_SRA : SF_SRL; end
            3'b110: begin r.func_class = FC_LOGIC; r.logic_fn = LF_OR; end
            default: begin r.func_class = FC_LOGIC; r.logic_fn = LF_AND; end
        endcase
        return r;
    endfunction

    always_comb begin
        ctl   = '0;
        legal = 1'b0;
        case (opcode)
            OPC_OP: begin
                legal = (funct7 == F7_ZERO) || (alt && (funct3 == 3'b000 || funct3 == 3'b101));
                ctl   = alu_fields(funct3, alt);
            end
            OPC_OP_IMM: begin
                // Shifts carry a 6-bit shamt, so only inst[31:26] is a function field.
                if (funct3 == 3'b001)
                    legal = (inst[31:26] == 6'b000000);
                else if (funct3 == 3'b101)
                    legal = (inst[31:26] == 6'b000000) || (inst[31:26] == 6'b010000);
                else
                    legal = 1'b1;
                ctl       = alu_fields(funct3, (funct3 == 3'b101) && inst[30]);
                ctl.b_sel = 1'b1;
                ctl.imm   = imm_i;
            end
`ifdef ALU_DECODE_WORD_OPS_EN
            OPC_OP_32: begin
                case (funct3)
                    3'b000, 3'b101: legal = (funct7 == F7_ZERO) || alt;
                    3'b001:         legal = (funct7 == F7_ZERO);
                    default:        legal = 1'b0;
                endcase
                ctl          = alu_fields(funct3, alt);
                ctl.ext_word = 1'b1;
            end
            OPC_OP_IMM_32: begin
                // Word shifts have a 5-bit shamt: inst[25] must stay clear.
                case (funct3)
                    3'b000:  legal = 1'b1;
                    3'b001:  legal = (funct7 == F7_ZERO);
                    3'b101:  legal = (funct7 == F7_ZERO) || alt;
                    default: legal = 1'b0;
                endcase
                ctl          = alu_fields(funct3, (funct3 == 3'b101) && alt);
                ctl.ext_word = 1'b1;
                ctl.b_sel    = 1'b1;
                ctl.imm      = imm_i;
            end
`else
            OPC_OP_32, OPC_OP_IMM_32: legal = 1'b0;
`endif
            OPC_LUI: begin
                legal        = 1'b1;
                ctl.logic_fn = LF_PASS_B;
                ctl.b_sel    = 1'b1;
                ctl.imm      = imm_u;
            end
            default: legal = 1'b0;
        endcase

        // Illegal instructions carry no controls, but register fields stay raw.
        if (!legal)
            ctl = '0;
        ctl.rs1     = inst[19:15];
        ctl.rs2     = inst[24:20];
        ctl.rd      = inst[11:7];
        ctl.illegal = !legal;
        dec         = ctl;
    end

endmodule

// File: rtl/alu_decode_stage.sv
// alu_decode_stage
//   One-cycle registered ALU decode stage with valid/ready handshake and a
//   saturating illegal-instruction counter.
//   Ports:
//     clk, reset_n                 clock, asynchronous active-low reset
//     in_valid/in_ready, in_inst   instruction handshake and word
//     out_valid/out_ready          decoded-bundle handshake
//     FuncClass, ShiftFn, LogicFn  execution-unit control fields (2 bits)
//     AddnSub, ExtWord, BSel       subtract, word op, B from immediate
//     Imm                          64-bit sign-extended immediate
//     rs1, rs2, rd                 register addresses
//     Illegal, IllegalCount        illegal flag, saturating illegal count
//   Optional feature: ALU_DECODE_WORD_OPS_EN enables word-op decoding.
module alu_decode_stage
    import alu_decode_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  FuncClass,
    output logic [1:0]  ShiftFn,
    output logic [1:0]  LogicFn,
    output logic        AddnSub,
    output logic        ExtWord,
    output logic        BSel,
    output logic [63:0] Imm,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        Illegal,
    output logic [15:0] IllegalCount
);

    decode_t     dec_p0;
    decode_t     dec_p1;
    logic        vld_p1;
    logic [15:0] ill_cnt;
    logic        accept;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    alu_decode_comb u_comb (
        .inst (in_inst),
        .dec  (dec_p0)
    );

    // Single-entry register: a new bundle may enter whenever the current one
    // is absent or leaving this cycle.
    assign in_ready = !vld_p1 || out_ready;
    assign accept   = in_valid && in_ready;

    // ---- stage p0 -> p1: decoded bundle register ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1  <= 1'b0;
            dec_p1  <= '0;
            ill_cnt <= '0;
        end else begin
            if (accept) begin
                dec_p1 <= dec_p0;
                vld_p1 <= 1'b1;
                if (dec_p0.illegal)
                    ill_cnt <= sat_inc(ill_cnt);
            end else if (out_ready) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign out_valid    = vld_p1;
    assign FuncClass    = dec_p1.func_class;
    assign ShiftFn      = dec_p1.shift_fn;
    assign LogicFn      = dec_p1.logic_fn;
    assign AddnSub      = dec_p1.addn_sub;
    assign ExtWord      = dec_p1.ext_word;
    assign BSel         = dec_p1.b_sel;
    assign Imm          = dec_p1.imm;
    assign rs1          = dec_p1.rs1;
    assign rs2          = dec_p1.rs2;
    assign rd           = dec_p1.rd;
    assign Illegal      = dec_p1.illegal;
    assign IllegalCount = ill_cnt;

endmodule

// File: tb/tb_alu_decode_stage.sv
module tb_alu_decode_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  FuncClass, ShiftFn, LogicFn;
    logic        AddnSub, ExtWord, BSel;
    logic [63:0] Imm;
    logic [4:0]  rs1, rs2, rd;
    logic        Illegal;
    logic [15:0] IllegalCount;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_decode_stage dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_inst      (in_inst),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .FuncClass    (FuncClass),
        .ShiftFn      (ShiftFn),
        .LogicFn      (LogicFn),
        .AddnSub      (AddnSub),
        .ExtWord      (ExtWord),
        .BSel         (BSel),
        .Imm          (Imm),
        .rs1          (rs1),
        .rs2          (rs2),
        .rd           (rd),
        .Illegal      (Illegal),
        .IllegalCount (IllegalCount)
    );

    typedef struct packed {
        logic [1:0]  fc;
        logic [1:0]  sf;
        logic [1:0]  lf;
        logic        as;
        logic        ew;
        logic        bs;
        logic [63:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        ill;
    } bundle_t;

    typedef struct packed {
        logic [31:0] inst;
        bundle_t     exp;
    } vec_t;

    // Reference instruction table: one row per legal mnemonic.
    typedef struct packed {
        logic [6:0] op;
        logic       f3_any;
        logic [2:0] f3;
        logic [6:0] top;
        logic [6:0] mask;
        logic [1:0] fc;
        logic [1:0] sf;
        logic [1:0] lf;
        logic       as;
        logic       ew;
        logic       bs;
        logic [1:0] immk;
    } pat_t;

    pat_t    pats[$];
    vec_t    vecs[$];
    bundle_t q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bundle_t dut_bundle();
        return {FuncClass, ShiftFn, LogicFn, AddnSub, ExtWord, BSel, Imm, rs1, rs2, rd, Illegal};
    endfunction

    function automatic bundle_t mk(input logic [1:0] fc, input logic [1:0] sf, input logic [1:0] lf,
                                   input logic as, input logic ew, input logic bs, input logic [63:0] imm,
                                   input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                                   input logic ill);
        return {fc, sf, lf, as, ew, bs, imm, r1, r2, d, ill};
    endfunction

    task automatic add_pat(input logic [6:0] op, input logic f3_any, input logic [2:0] f3,
                           input logic [6:0] top, input logic [6:0] mask, input logic [1:0] fc,
                           input logic [1:0] sf, input logic [1:0] lf, input logic as,
                           input logic ew, input logic bs, input logic [1:0] immk);
        pats.push_back({op, f3_any, f3, top, mask, fc, sf, lf, as, ew, bs, immk});
    endtask

    function automatic bundle_t model(input logic [31:0] inst);
        bundle_t b;
        longint  v;
        b     = '0;
        b.ill = 1'b1;
        foreach (pats[i]) begin
            if (b.ill && inst[6:0] == pats[i].op &&
                (pats[i].f3_any || inst[14:12] == pats[i].f3) &&
                ((inst[31:25] & pats[i].mask) == (pats[i].top & pats[i].mask))) begin
                b.ill = 1'b0;
                b.fc  = pats[i].fc;
                b.sf  = pats[i].sf;
                b.lf  = pats[i].lf;
                b.as  = pats[i].as;
                b.ew  = pats[i].ew;
                b.bs  = pats[i].bs;
                if (pats[i].immk == 2'd1) begin
                    v     = longint'($signed(inst[31:20]));
                    b.imm = v;
                end else if (pats[i].immk == 2'd2) begin
                    v     = longint'($signed(inst[31:12])) * 4096;
                    b.imm = v;
                end
            end
        end
        b.rs1 = inst[19:15];
        b.rs2 = inst[24:20];
        b.rd  = inst[11:7];
        return b;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0]  op;
        logic [6:0]  top;
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 5))
            0: op = 7'h33;
            1: op = 7'h13;
            2: op = 7'h3B;
            3: op = 7'h1B;
            4: op = 7'h37;
            default: op = 7'($urandom);
        endcase
        case ($urandom_range(0, 3))
            0: top = 7'h00;
            1: top = 7'h20;
            2: top = 7'h01;
            default: top = 7'($urandom);
        endcase
        return {top, r[24:7], op};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bundle_t snap;
        bundle_t prev;
        bundle_t e;
        logic    prev_stall;
        int      n_ill;
        int      exp_cnt;

        // Reference table: OP
        add_pat(7'h33, 0, 3'd0, 7'h00, 7'h7F, 2'd1, 2'd0, 2'd0, 0, 0, 0, 2'd0);
        add_pat(7'h33, 0, 3'd0, 7'h20, 7'h7F, 2'd1, 2'd0, 2'd0, 1, 0, 0, 2'd0);
        add_pat(7'h33, 0, 3'd1, 7'h00, 7'h7F, 2'd1, 2'd1, 2'd0, 0, 0, 0, 2'd0);
        add_pat(7'h33, 0, 3'd2, 7'h00, 7'h7F, 2'd2, 2'd0, 2'd0, 1, 0, 0, 2'd0);
        add_pat(7'h33, 0, 3'd3, 7'h00, 7'h7F, 2'd3, 2'd0, 2'd0, 1, 0, 0, 2'd0);
        add_pat(7'h33, 0, 3'd4, 7'h00, 7'h7F, 2'd0, 2'd0, 2'd2, 0, 0, 0, 2'd0);
        add_pat(7'h33, 0, 3'd5, 7'h00, 7'h7F, 2'd1, 2'd2, 2'd0, 0, 0, 0, 2'd0);
        add_pat(7'h33, 0, 3'd5, 7'h20, 7'h7F, 2'd1, 2'd3, 2'd0, 0, 0, 0, 2'd0);
        add_pat(7'h33, 0, 3'd6, 7'h00, 7'h7F, 2'd0, 2'd0, 2'd1, 0, 0, 0, 2'd0);
        add_pat(7'h33, 0, 3'd7, 7'h00, 7'h7F, 2'd0, 2'd0, 2'd0, 0, 0, 0, 2'd0);
        // OP-IMM
        add_pat(7'h13, 0, 3'd0, 7'h00, 7'h00, 2'd1, 2'd0, 2'd0, 0, 0, 1, 2'd1);
        add_pat(7'h13, 0, 3'd1, 7'h00, 7'h7E, 2'd1, 2'd1, 2'd0, 0, 0, 1, 2'd1);
        add_pat(7'h13, 0, 3'd2, 7'h00, 7'h00, 2'd2, 2'd0, 2'd0, 1, 0, 1, 2'd1);
        add_pat(7'h13, 0, 3'd3, 7'h00, 7'h00, 2'd3, 2'd0, 2'd0, 1, 0, 1, 2'd1);
        add_pat(7'h13, 0, 3'd4, 7'h00, 7'h00, 2'd0, 2'd0, 2'd2, 0, 0, 1, 2'd1);
        add_pat(7'h13, 0, 3'd5, 7'h00, 7'h7E, 2'd1, 2'd2, 2'd0, 0, 0, 1, 2'd1);
        add_pat(7'h13, 0, 3'd5, 7'h20, 7'h7E, 2'd1, 2'd3, 2'd0, 0, 0, 1, 2'd1);
        add_pat(7'h13, 0, 3'd6, 7'h00, 7'h00, 2'd0, 2'd0, 2'd1, 0, 0, 1, 2'd1);
        add_pat(7'h13, 0, 3'd7, 7'h00, 7'h00, 2'd0, 2'd0, 2'd0, 0, 0, 1, 2'd1);
`ifdef ALU_DECODE_WORD_OPS_EN
        add_pat(7'h3B, 0, 3'd0, 7'h00, 7'h7F, 2'd1, 2'd0, 2'd0, 0, 1, 0, 2'd0);
        add_pat(7'h3B, 0, 3'd0, 7'h20, 7'h7F, 2'd1, 2'd0, 2'd0, 1, 1, 0, 2'd0);
        add_pat(7'h3B, 0, 3'd1, 7'h00, 7'h7F, 2'd1, 2'd1, 2'd0, 0, 1, 0, 2'd0);
        add_pat(7'h3B, 0, 3'd5, 7'h00, 7'h7F, 2'd1, 2'd2, 2'd0, 0, 1, 0, 2'd0);
        add_pat(7'h3B, 0, 3'd5, 7'h20, 7'h7F, 2'd1, 2'd3, 2'd0, 0, 1, 0, 2'd0);
        add_pat(7'h1B, 0, 3'd0, 7'h00, 7'h00, 2'd1, 2'd0, 2'd0, 0, 1, 1, 2'd1);
        add_pat(7'h1B, 0, 3'd1, 7'h00, 7'h7F, 2'd1, 2'd1, 2'd0, 0, 1, 1, 2'd1);
        add_pat(7'h1B, 0, 3'd5, 7'h00, 7'h7F, 2'd1, 2'd2, 2'd0, 0, 1, 1, 2'd1);
        add_pat(7'h1B, 0, 3'd5, 7'h20, 7'h7F, 2'd1, 2'd3, 2'd0, 0, 1, 1, 2'd1);
`endif
        add_pat(7'h37, 1, 3'd0, 7'h00, 7'h00, 2'd0, 2'd0, 2'd3, 0, 0, 1, 2'd2);

        // Directed vectors with hand-derived expectations
        vecs.push_back({32'h002081B3, mk(2'd1, 2'd0, 2'd0, 0, 0, 0, 64'h0, 5'd1, 5'd2, 5'd3, 0)});
        vecs.push_back({32'h402081B3, mk(2'd1, 2'd0, 2'd0, 1, 0, 0, 64'h0, 5'd1, 5'd2, 5'd3, 0)});
        vecs.push_back({32'h43F35293, mk(2'd1, 2'd3, 2'd0, 0, 0, 1, 64'h43F, 5'd6, 5'd31, 5'd5, 0)});
        vecs.push_back({32'h02208133, mk(2'd0, 2'd0, 2'd0, 0, 0, 0, 64'h0, 5'd1, 5'd2, 5'd2, 1)});
`ifdef ALU_DECODE_WORD_OPS_EN
        vecs.push_back({32'h002081BB, mk(2'd1, 2'd0, 2'd0, 0, 1, 0, 64'h0, 5'd1, 5'd2, 5'd3, 0)});
`else
        vecs.push_back({32'h002081BB, mk(2'd0, 2'd0, 2'd0, 0, 0, 0, 64'h0, 5'd1, 5'd2, 5'd3, 1)});
`endif
        vecs.push_back({32'h800000B7, mk(2'd0, 2'd0, 2'd3, 0, 0, 1, 64'hFFFFFFFF80000000, 5'd0, 5'd0, 5'd1, 0)});
        vecs.push_back({32'hFFF10093, mk(2'd1, 2'd0, 2'd0, 0, 0, 1, 64'hFFFFFFFFFFFFFFFF, 5'd2, 5'd31, 5'd1, 0)});
        vecs.push_back({32'h0062B233, mk(2'd3, 2'd0, 2'd0, 1, 0, 0, 64'h0, 5'd5, 5'd6, 5'd4, 0)});
        vecs.push_back({32'h7FF44393, mk(2'd0, 2'd0, 2'd2, 0, 0, 1, 64'h7FF, 5'd8, 5'd31, 5'd7, 0)});
        vecs.push_back({32'h40109093, mk(2'd0, 2'd0, 2'd0, 0, 0, 0, 64'h0, 5'd1, 5'd1, 5'd1, 1)});
        vecs.push_back({32'h4020F1B3, mk(2'd0, 2'd0, 2'd0, 0, 0, 0, 64'h0, 5'd1, 5'd2, 5'd3, 1)});
        vecs.push_back({32'h0000A083, mk(2'd0, 2'd0, 2'd0, 0, 0, 0, 64'h0, 5'd1, 5'd0, 5'd1, 1)});
        vecs.push_back({32'h4020D1B3, mk(2'd1, 2'd3, 2'd0, 0, 0, 0, 64'h0, 5'd1, 5'd2, 5'd3, 0)});
        vecs.push_back({32'h0020E1B3, mk(2'd0, 2'd0, 2'd1, 0, 0, 0, 64'h0, 5'd1, 5'd2, 5'd3, 0)});

        // Reset state
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_inst   = 32'h0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_count", IllegalCount, 16'h0);
        check("rst_bundle", dut_bundle(), '0);
        reset_n = 1'b1;

        // Table-driven vectors at full throughput
        n_ill = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            in_valid  = 1'b1;
            in_inst   = vecs[i].inst;
            out_ready = 1'b1;
            tick();
            check($sformatf("vec%0d_valid", i), out_valid, 1'b1);
            check($sformatf("vec%0d_bundle", i), dut_bundle(), vecs[i].exp);
            if (vecs[i].exp.ill) n_ill++;
        end
        check("table_count", IllegalCount, 16'(n_ill));

        // SUB then SRAI back to back, no gap
        in_inst = 32'h402081B3;
        tick();
        check("b2b_sub_valid", out_valid, 1'b1);
        check("b2b_sub_as", AddnSub, 1'b1);
        in_inst = 32'h43F35293;
        tick();
        check("b2b_srai_valid", out_valid, 1'b1);
        check("b2b_srai_sf", ShiftFn, 2'b11);
        check("b2b_srai_bsel", BSel, 1'b1);
        check("b2b_srai_imm", Imm[5:0], 6'd63);
        check("b2b_srai_rd", rd, 5'd5);

        // Stall for 3 cycles with a bundle held
        in_inst = 32'h002081B3;
        tick();
        snap      = dut_bundle();
        out_ready = 1'b0;
        in_inst   = 32'h0020E1B3;
        #1;
        check("stall_in_ready", in_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall%0d_valid", i), out_valid, 1'b1);
            check($sformatf("stall%0d_hold", i), dut_bundle(), snap);
            check($sformatf("stall%0d_ready", i), in_ready, 1'b0);
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", in_ready, 1'b1);
        tick();
        check("release_bundle", dut_bundle(), mk(2'd0, 2'd0, 2'd1, 0, 0, 0, 64'h0, 5'd1, 5'd2, 5'd3, 0));

        // Asynchronous reset in the middle of a stall
        in_inst = 32'h002081B3;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        check("prerst_valid", out_valid, 1'b1);
        check("prerst_count", IllegalCount, 16'(n_ill));
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 1'b0);
        check("async_rst_count", IllegalCount, 16'h0);
        check("async_rst_ready", in_ready, 1'b1);
        check("async_rst_bundle", dut_bundle(), '0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Randomized traffic against the reference model
        exp_cnt    = 0;
        prev_stall = 1'b0;
        prev       = '0;
        for (int c = 0; c < 3000; c++) begin
            if (prev_stall)
                check("rand_hold", dut_bundle(), prev);
            check("rand_out_valid", out_valid, q.size() != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_inst   = rand_inst();
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            check("rand_in_ready", in_ready, !out_valid || out_ready);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rand_unexpected: got out_valid=1 expected no bundle");
                end else begin
                    e = q.pop_front();
                    check("rand_bundle", dut_bundle(), e);
                end
            end
            if (in_valid && in_ready) begin
                e = model(in_inst);
                q.push_back(e);
                if (e.ill && exp_cnt < 65535) exp_cnt++;
            end
            prev       = dut_bundle();
            prev_stall = out_valid && !out_ready;
            tick();
            check("rand_count", IllegalCount, 16'(exp_cnt));
        end
        in_valid = 1'b0;

        // Counter saturation
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        in_valid  = 1'b1;
        in_inst   = 32'h02208133;
        out_ready = 1'b1;
        tick();
        check("mul_bundle", dut_bundle(), mk(2'd0, 2'd0, 2'd0, 0, 0, 0, 64'h0, 5'd1, 5'd2, 5'd2, 1));
        check("mul_count", IllegalCount, 16'd1);
        repeat (16'hFFFE) @(posedge clk);
        #1;
        check("sat_reach", IllegalCount, 16'hFFFF);
        repeat (2) @(posedge clk);
        #1;
        check("sat_hold", IllegalCount, 16'hFFFF);
        in_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
